// File: rtl/move_list_reader_pkg.sv
// chess_pkg: shared types and constants for the move-list reader.
//   SQ_W            square index width (square = rank*8 + file)
//   SL_*            field positions inside an 11-bit sliding word
//   KN_*            field positions inside an 8-bit knight word
//   dir_e / DELTA   sliding directions in emission order and their steps
//   state_e         reader FSM states
//   ray_room()      squares available before a ray leaves the board
package chess_pkg;

  localparam int SQ_W = 6;

  localparam int SL_LEN_MSB = 2;
  localparam int SL_CAP_BIT = 3;

  localparam int KN_DST_MSB = 5;
  localparam int KN_DST_LSB = 0;
  localparam int KN_CAP_BIT = 6;
  localparam int KN_VLD_BIT = 7;

  typedef enum logic [2:0] {
    DIR_U, DIR_D, DIR_L, DIR_R, DIR_UL, DIR_UR, DIR_DL, DIR_DR
  } dir_e;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] df;
  } delta_t;

  // Indexed by dir_e.
  localparam delta_t DELTA [8] = '{
    '{dr: 2'sb01, df: 2'sb00},
    '{dr: 2'sb11, df: 2'sb00},
    '{dr: 2'sb00, df: 2'sb11},
    '{dr: 2'sb00, df: 2'sb01},
    '{dr: 2'sb01, df: 2'sb11},
    '{dr: 2'sb01, df: 2'sb01},
    '{dr: 2'sb11, df: 2'sb11},
    '{dr: 2'sb11, df: 2'sb01}
  };

  typedef enum logic [1:0] {ST_IDLE, ST_SLIDE, ST_KNIGHT, ST_DONE} state_e;

  function automatic logic [2:0] ray_room(input logic [SQ_W-1:0] sq, input dir_e d);
    logic [2:0] rank, file, rr, fr;
    rank = sq[5:3];
    file = sq[2:0];
    case (DELTA[d].dr)
      2'b01:   rr = 3'd7 - rank;
      2'b11:   rr = rank;
      default: rr = 3'd7;
    endcase
    case (DELTA[d].df)
      2'b01:   fr = 3'd7 - file;
      2'b11:   fr = file;
      default: fr = 3'd7;
    endcase
    return (rr < fr) ? rr : fr;
  endfunction

endpackage

// File: rtl/move_list_reader_if.sv
// Move stream: one (from, to, capture) move per transfer, valid/ready.
//   master: drives mv_valid, mv_from, mv_to, mv_cap; samples mv_ready
//   slave : the consumer side
interface move_list_reader_if #(parameter int SQ_W = 6);
  logic            mv_valid;
  logic            mv_ready;
  logic [SQ_W-1:0] mv_from;
  logic [SQ_W-1:0] mv_to;
  logic            mv_cap;

  modport master (output mv_valid, mv_from, mv_to, mv_cap, input mv_ready);
  modport slave  (input mv_valid, mv_from, mv_to, mv_cap, output mv_ready);
endinterface

// File: rtl/move_list_reader_sq_step.sv
// sq_step: destination of step k along a (rank, file) delta from origin.
//   origin   square index
//   dr, df   rank / file delta, each -1..+1
//   k        step number
//   dst      destination square (low bits of rank and file)
//   on_board destination rank and file both inside 0..7
module sq_step
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0]  origin,
  input  logic signed [1:0] dr,
  input  logic signed [1:0] df,
  input  logic [2:0]       k,
  output logic [SQ_W-1:0]  dst,
  output logic             on_board
);

  logic signed [4:0] rank_x, file_x, dr_x, df_x, k_x, r, f;

  assign rank_x = {2'b00, origin[5:3]};
  assign file_x = {2'b00, origin[2:0]};
  assign dr_x   = {{3{dr[1]}}, dr};
  assign df_x   = {{3{df[1]}}, df};
  assign k_x    = {2'b00, k};

  assign r = rank_x + dr_x * k_x;
  assign f = file_x + df_x * k_x;

  assign on_board = (r >= 5'sd0) && (r <= 5'sd7) && (f >= 5'sd0) && (f <= 5'sd7);
  assign dst      = {r[2:0], f[2:0]};

endmodule

// File: rtl/move_list_reader.sv
// move_list_reader: expands one origin square's move-word snapshot into a
// stream of individual moves, one per cycle.
//   CLOCK, RESET_N          clock, async active-low reset
//   load_valid/load_ready   snapshot handshake; from_sq + 16 words captured
//   U_in..DR_in             sliding words: [2:0] length, [3] capture at end
//   UUL_in..RRD_in          knight words: [5:0] dst, [6] capture, [7] valid
//   mv                      registered move stream (master side)
//   done                    one-cycle pulse after the last move
//   move_count              moves accepted for the current/last snapshot
//
// state     | meaning
// ST_IDLE   | waiting for a snapshot, load_ready high
// ST_SLIDE  | emitting sliding-ray moves
// ST_KNIGHT | emitting knight jumps
// ST_DONE   | done pulse, back to idle next cycle
module move_list_reader #(
  parameter int SQ_W  = 6,
  parameter int CNT_W = 7
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [SQ_W-1:0]   from_sq,
  input  logic [10:0]       U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in,
  input  logic [7:0]        UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in,
  move_list_reader_if.master mv,
  output logic              done,
  output logic [CNT_W-1:0]  move_count
);
  import chess_pkg::*;

  state_e state, state_nxt, phase_nxt;
  logic   advance;

  logic [7:0][10:0]     slide_w;
  logic [7:0][7:0]      knight_w;
  logic [7:0][2:0]      room, len_in, len_r, len_src;
  logic [7:0]           scap_in, scap_r, scap_src;
  logic [7:0][SQ_W-1:0] kdst_in, kdst_r, kdst_src;
  logic [7:0]           kcap_in, kcap_r, kcap_src;
  logic [7:0]           kvld_in, kvld_r, kvld_src;
  logic [SQ_W-1:0]      from_r, from_src;

  logic [2:0] cur_dir, cur_k, nd, nk, s_sel, k_sel;
  logic [3:0] slide_lo, knight_lo;
  logic       slide_en, ray_more, s_found, k_found;

  logic [SQ_W-1:0] step_dst, nxt_to;
  logic            step_on_board, nxt_cap;
  logic            mv_valid_r, mv_cap_r;
  logic [SQ_W-1:0] mv_from_r, mv_to_r;
  logic            unused_bits;

  assign slide_w  = {DR_in, DL_in, UR_in, UL_in, R_in, L_in, D_in, U_in};
  assign knight_w = {RRD_in, LLD_in, DDR_in, DDL_in, RRU_in, LLU_in, UUR_in, UUL_in};

  // A ray never re-enters the board once it leaves it, so clamping each
  // length to the room left on the board at load time is the same as
  // stopping at the first off-board step. The capture only survives when
  // the requested length fits entirely.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      room[i]    = ray_room(from_sq, dir_e'(3'(i)));
      len_in[i]  = (slide_w[i][SL_LEN_MSB:0] <= room[i]) ? slide_w[i][SL_LEN_MSB:0] : room[i];
      scap_in[i] = slide_w[i][SL_CAP_BIT] && (slide_w[i][SL_LEN_MSB:0] <= room[i]);
      kdst_in[i] = knight_w[i][KN_DST_MSB:KN_DST_LSB];
      kcap_in[i] = knight_w[i][KN_CAP_BIT];
      kvld_in[i] = knight_w[i][KN_VLD_BIT];
    end
  end

  // In IDLE the first move is selected straight from the load inputs so it
  // can be registered on the load edge.
  always_comb begin
    if (state == ST_IDLE) begin
      from_src = from_sq;  len_src  = len_in;  scap_src = scap_in;
      kdst_src = kdst_in;  kcap_src = kcap_in; kvld_src = kvld_in;
    end else begin
      from_src = from_r;   len_src  = len_r;   scap_src = scap_r;
      kdst_src = kdst_r;   kcap_src = kcap_r;  kvld_src = kvld_r;
    end
  end

  // Next-move selection: continue the current ray, else the lowest remaining
  // non-empty ray, else the lowest remaining valid knight word.
  always_comb begin
    slide_en  = 1'b0;
    slide_lo  = 4'd0;
    knight_lo = 4'd8;
    ray_more  = 1'b0;
    case (state)
      ST_IDLE: begin
        slide_en  = 1'b1;
        knight_lo = 4'd0;
      end
      ST_SLIDE: begin
        slide_en  = 1'b1;
        slide_lo  = {1'b0, cur_dir} + 4'd1;
        knight_lo = 4'd0;
        ray_more  = cur_k < len_src[cur_dir];
      end
      ST_KNIGHT: knight_lo = {1'b0, cur_dir} + 4'd1;
      default: ;
    endcase

    s_found = 1'b0;
    s_sel   = 3'd0;
    k_found = 1'b0;
    k_sel   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (slide_en && (4'(i) >= slide_lo) && (len_src[i] != 3'd0)) begin
        s_found = 1'b1;
        s_sel   = 3'(i);
      end
      if ((4'(i) >= knight_lo) && kvld_src[i]) begin
        k_found = 1'b1;
        k_sel   = 3'(i);
      end
    end

    phase_nxt = ST_DONE;
    nd        = 3'd0;
    nk        = 3'd0;
    if (ray_more) begin
      phase_nxt = ST_SLIDE;
      nd        = cur_dir;
      nk        = cur_k + 3'd1;
    end else if (s_found) begin
      phase_nxt = ST_SLIDE;
      nd        = s_sel;
      nk        = 3'd1;
    end else if (k_found) begin
      phase_nxt = ST_KNIGHT;
      nd        = k_sel;
    end
  end

  sq_step u_sq_step (
    .origin   (from_src),
    .dr       (DELTA[nd].dr),
    .df       (DELTA[nd].df),
    .k        (nk),
    .dst      (step_dst),
    .on_board (step_on_board)
  );

  assign nxt_to  = (phase_nxt == ST_KNIGHT) ? kdst_src[nd] : step_dst;
  assign nxt_cap = (phase_nxt == ST_KNIGHT) ? kcap_src[nd]
                                            : (scap_src[nd] && (nk == len_src[nd]));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      ST_IDLE: if (load_valid) begin
        advance   = 1'b1;
        state_nxt = phase_nxt;
      end
      ST_SLIDE, ST_KNIGHT: if (mv.mv_ready) begin
        advance   = 1'b1;
        state_nxt = phase_nxt;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      from_r     <= '0;
      len_r      <= '0;
      scap_r     <= '0;
      kdst_r     <= '0;
      kcap_r     <= '0;
      kvld_r     <= '0;
      cur_dir    <= '0;
      cur_k      <= '0;
      mv_valid_r <= 1'b0;
      mv_from_r  <= '0;
      mv_to_r    <= '0;
      mv_cap_r   <= 1'b0;
      move_count <= '0;
    end else begin
      if (state == ST_IDLE && load_valid) begin
        from_r     <= from_sq;
        len_r      <= len_in;
        scap_r     <= scap_in;
        kdst_r     <= kdst_in;
        kcap_r     <= kcap_in;
        kvld_r     <= kvld_in;
        move_count <= '0;
      end
      if (mv_valid_r && mv.mv_ready) move_count <= move_count + CNT_W'(1);
      if (advance) begin
        cur_dir    <= nd;
        cur_k      <= nk;
        mv_valid_r <= (phase_nxt != ST_DONE);
        if (phase_nxt != ST_DONE) begin
          mv_from_r <= from_src;
          mv_to_r   <= nxt_to;
          mv_cap_r  <= nxt_cap;
        end
      end
    end
  end

  // Reserved slide bits are ignored; on_board is redundant after clamping.
  always_comb begin
    unused_bits = step_on_board;
    for (int i = 0; i < 8; i++) unused_bits = unused_bits ^ (^slide_w[i][10:4]);
  end

  assign load_ready  = (state == ST_IDLE);
  assign done        = (state == ST_DONE);
  assign mv.mv_valid = mv_valid_r;
  assign mv.mv_from  = mv_from_r;
  assign mv.mv_to    = mv_to_r;
  assign mv.mv_cap   = mv_cap_r;

endmodule

// File: tb/tb_move_list_reader.sv
module tb_move_list_reader;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  from_sq = '0;
  logic [10:0] U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in;
  logic [7:0]  UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in;
  logic        done;
  logic [6:0]  move_count;

  int n_checks = 0;
  int n_pass   = 0;

  move_list_reader_if #(.SQ_W(6)) mv();

  move_list_reader #(.SQ_W(6), .CNT_W(7)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .load_valid(load_valid), .load_ready(load_ready), .from_sq(from_sq),
    .U_in(U_in), .D_in(D_in), .L_in(L_in), .R_in(R_in),
    .UL_in(UL_in), .UR_in(UR_in), .DL_in(DL_in), .DR_in(DR_in),
    .UUL_in(UUL_in), .UUR_in(UUR_in), .LLU_in(LLU_in), .RRU_in(RRU_in),
    .DDL_in(DDL_in), .DDR_in(DDR_in), .LLD_in(LLD_in), .RRD_in(RRD_in),
    .mv(mv), .done(done), .move_count(move_count)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_words();
    U_in = '0;   D_in = '0;   L_in = '0;   R_in = '0;
    UL_in = '0;  UR_in = '0;  DL_in = '0;  DR_in = '0;
    UUL_in = '0; UUR_in = '0; LLU_in = '0; RRU_in = '0;
    DDL_in = '0; DDR_in = '0; LLD_in = '0; RRD_in = '0;
  endtask

  // Leaves the bench in cycle N+1 after load edge N.
  task automatic do_load(input logic [5:0] sq);
    from_sq = sq;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    clear_words();
  endtask

  task automatic test_reset();
    clear_words();
    mv.mv_ready = 1'b1;
    RESET_N = 1'b0;
    tick();
    n_checks++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b want 1", load_ready); else n_pass++;
    n_checks++; if (mv.mv_valid !== 1'b0) $display("FAIL rst_mv_valid: got %b want 0", mv.mv_valid); else n_pass++;
    n_checks++; if ({mv.mv_from, mv.mv_to, mv.mv_cap} !== 13'd0) $display("FAIL rst_mv_fields: got from=%0d to=%0d cap=%b want 0 0 0", mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (move_count !== 7'd0) $display("FAIL rst_count: got %0d want 0", move_count); else n_pass++;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_single_ray();
    U_in = 11'h00A;
    do_load(6'd27);
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd27, 6'd35, 1'b0}) $display("FAIL ray_move1: got v=%b from=%0d to=%0d cap=%b want 1 27 35 0", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    n_checks++; if (load_ready !== 1'b0) $display("FAIL ray_load_ready: got %b want 0", load_ready); else n_pass++;
    tick();
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd27, 6'd43, 1'b1}) $display("FAIL ray_move2: got v=%b from=%0d to=%0d cap=%b want 1 27 43 1", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    tick();
    n_checks++; if ({mv.mv_valid, done, load_ready} !== 3'b010) $display("FAIL ray_done: got v=%b done=%b ready=%b want 0 1 0", mv.mv_valid, done, load_ready); else n_pass++;
    n_checks++; if (move_count !== 7'd2) $display("FAIL ray_count: got %0d want 2", move_count); else n_pass++;
    tick();
    n_checks++; if ({done, load_ready} !== 2'b01) $display("FAIL ray_idle: got done=%b ready=%b want 0 1", done, load_ready); else n_pass++;
    n_checks++; if (move_count !== 7'd2) $display("FAIL ray_count_hold: got %0d want 2", move_count); else n_pass++;
  endtask

  task automatic test_empty();
    do_load(6'd27);
    n_checks++; if ({mv.mv_valid, done} !== 2'b01) $display("FAIL empty_done: got v=%b done=%b want 0 1", mv.mv_valid, done); else n_pass++;
    n_checks++; if (move_count !== 7'd0) $display("FAIL empty_count: got %0d want 0", move_count); else n_pass++;
    tick();
    n_checks++; if ({done, load_ready} !== 2'b01) $display("FAIL empty_idle: got done=%b ready=%b want 0 1", done, load_ready); else n_pass++;
  endtask

  task automatic test_corner();
    L_in = 11'h003;
    D_in = 11'h00A;
    R_in = 11'h001;
    do_load(6'd0);
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd0, 6'd1, 1'b0}) $display("FAIL corner_move: got v=%b from=%0d to=%0d cap=%b want 1 0 1 0", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    tick();
    n_checks++; if ({mv.mv_valid, done} !== 2'b01) $display("FAIL corner_done: got v=%b done=%b want 0 1", mv.mv_valid, done); else n_pass++;
    n_checks++; if (move_count !== 7'd1) $display("FAIL corner_count: got %0d want 1", move_count); else n_pass++;
    tick();
  endtask

  // h1: full-length U and L rays to the board edge, R and DL fully off board.
  task automatic test_full_edges();
    logic [5:0] exp_to [14];
    logic       exp_cap [14];
    exp_to  = '{6'd15, 6'd23, 6'd31, 6'd39, 6'd47, 6'd55, 6'd63, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    exp_cap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    U_in  = 11'h7FF;
    R_in  = 11'h00A;
    L_in  = 11'h00F;
    DL_in = 11'h00D;
    do_load(6'd7);
    for (int i = 0; i < 14; i++) begin
      n_checks++;
      if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd7, exp_to[i], exp_cap[i]})
        $display("FAIL edge_move%0d: got v=%b from=%0d to=%0d cap=%b want 1 7 %0d %b", i, mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap, exp_to[i], exp_cap[i]);
      else n_pass++;
      tick();
    end
    n_checks++; if ({mv.mv_valid, done} !== 2'b01) $display("FAIL edge_done: got v=%b done=%b want 0 1", mv.mv_valid, done); else n_pass++;
    n_checks++; if (move_count !== 7'd14) $display("FAIL edge_count: got %0d want 14", move_count); else n_pass++;
    tick();
  endtask

  task automatic test_knight();
    UUL_in = 8'hE3;
    RRD_in = 8'h96;
    do_load(6'd28);
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd28, 6'd35, 1'b1}) $display("FAIL knight_move1: got v=%b from=%0d to=%0d cap=%b want 1 28 35 1", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    tick();
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd28, 6'd22, 1'b0}) $display("FAIL knight_move2: got v=%b from=%0d to=%0d cap=%b want 1 28 22 0", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    tick();
    n_checks++; if ({done, move_count} !== {1'b1, 7'd2}) $display("FAIL knight_done: got done=%b count=%0d want 1 2", done, move_count); else n_pass++;
    tick();
  endtask

  // d4: U ray, partly clamped DL ray (capture dropped), then a knight jump.
  task automatic test_back_to_back();
    logic [5:0] exp_to [6];
    logic       exp_cap [6];
    exp_to  = '{6'd35, 6'd43, 6'd18, 6'd9, 6'd0, 6'd33};
    exp_cap = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    U_in   = 11'h00A;
    DL_in  = 11'h00D;
    LLU_in = 8'hE1;
    do_load(6'd27);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd27, exp_to[i], exp_cap[i]})
        $display("FAIL b2b_move%0d: got v=%b from=%0d to=%0d cap=%b want 1 27 %0d %b", i, mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap, exp_to[i], exp_cap[i]);
      else n_pass++;
      tick();
    end
    n_checks++; if ({done, move_count} !== {1'b1, 7'd6}) $display("FAIL b2b_done: got done=%b count=%0d want 1 6", done, move_count); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    U_in = 11'h00A;
    mv.mv_ready = 1'b0;
    do_load(6'd27);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap, move_count} !== {1'b1, 6'd27, 6'd35, 1'b0, 7'd0})
        $display("FAIL stall_hold%0d: got v=%b from=%0d to=%0d cap=%b count=%0d want 1 27 35 0 0", i, mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap, move_count);
      else n_pass++;
      tick();
    end
    mv.mv_ready = 1'b1;
    n_checks++; if ({mv.mv_valid, mv.mv_to} !== {1'b1, 6'd35}) $display("FAIL stall_release: got v=%b to=%0d want 1 35", mv.mv_valid, mv.mv_to); else n_pass++;
    tick();
    n_checks++; if ({mv.mv_valid, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd43, 1'b1}) $display("FAIL stall_move2: got v=%b to=%0d cap=%b want 1 43 1", mv.mv_valid, mv.mv_to, mv.mv_cap); else n_pass++;
    tick();
    n_checks++; if ({done, move_count} !== {1'b1, 7'd2}) $display("FAIL stall_done: got done=%b count=%0d want 1 2", done, move_count); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    U_in = 11'h007;
    do_load(6'd0);
    tick();
    tick();
    tick();
    n_checks++; if ({mv.mv_to, move_count} !== {6'd32, 7'd3}) $display("FAIL mid_before: got to=%0d count=%0d want 32 3", mv.mv_to, move_count); else n_pass++;
    RESET_N = 1'b0;
    #1;
    n_checks++; if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== 14'd0) $display("FAIL mid_rst_mv: got v=%b from=%0d to=%0d cap=%b want all 0", mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap); else n_pass++;
    n_checks++; if ({done, load_ready, move_count} !== {1'b0, 1'b1, 7'd0}) $display("FAIL mid_rst_ctl: got done=%b ready=%b count=%0d want 0 1 0", done, load_ready, move_count); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL mid_rst_nodone: got %b want 0", done); else n_pass++;
    RESET_N = 1'b1;
    #2;
    U_in = 11'h007;
    do_load(6'd0);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if ({mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap} !== {1'b1, 6'd0, 6'(8 * (i + 1)), 1'b0})
        $display("FAIL mid_fresh%0d: got v=%b from=%0d to=%0d cap=%b want 1 0 %0d 0", i, mv.mv_valid, mv.mv_from, mv.mv_to, mv.mv_cap, 8 * (i + 1));
      else n_pass++;
      tick();
    end
    n_checks++; if ({done, move_count} !== {1'b1, 7'd7}) $display("FAIL mid_fresh_done: got done=%b count=%0d want 1 7", done, move_count); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ray();
    test_empty();
    test_corner();
    test_full_edges();
    test_knight();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/move_list_reader.md
# move_list_reader

Consumer side of the move-register stage. It accepts one latched snapshot of the 16 per-direction move words for a single origin square: 8 sliding rays of 11 bits and 8 knight jumps of 8 bits. It then expands the snapshot into individual (from, to, capture) moves and emits them one per cycle over a valid/ready stream. The downstream consumer is the search/evaluation front end.

## Interface
- `SQ_W`, default 6: square index width; square = rank*8 + file.
- `CNT_W`, default 7: width of the emitted-move counter. Maximum is 7*8 + 8 = 64 moves.

Ports:
- `CLOCK` in 1: single clock, rising-edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `load_valid` in 1: snapshot present on the load inputs.
- `load_ready` out 1: block is idle and able to accept a snapshot.
- `from_sq` in SQ_W: origin square of the snapshot.
- `U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in` in 11 each: sliding words.
  - [2:0] reach length, 0..7.
  - [3] last reached square is a capture.
  - [10:4] reserved, ignored.
- `UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in` in 8 each: knight words.
  - [5:0] destination square.
  - [6] capture.
  - [7] valid.
- `mv_valid` out 1: move present.
- `mv_ready` in 1: consumer accepts.
- `mv_from`, `mv_to` out SQ_W: move squares.
- `mv_cap` out 1: capture flag.
- `done` out 1: one-cycle pulse after the last move of a snapshot.
- `move_count` out CNT_W: number of moves emitted for the current/last snapshot.

## Operation
- States:
  - IDLE: `load_ready`=1.
  - SLIDE: ray expansion.
  - KNIGHT: jump expansion.
  - DONE: emits the `done` pulse.
- Load:
  - The load handshake completes when `load_valid && load_ready` at a rising edge.
  - On load, all 16 words and `from_sq` are captured into internal registers, and `move_count` is cleared.
  - Inputs are ignored outside IDLE.
- SLIDE order is U, D, L, R, UL, UR, DL, DR.
  - For each direction, steps k = 1..len are emitted with `mv_to` = from + k·delta.
  - Deltas are (rank, file): U(+1,0), D(-1,0), L(0,-1), R(0,+1), UL(+1,-1), UR(+1,+1), DL(-1,-1), DR(-1,+1).
  - `mv_cap` = bit3 only on step k == len; it is 0 for all other steps.
  - A direction with len=0 is skipped in zero cycles; the next non-empty direction is selected combinationally.
  - Any step whose rank or file leaves 0..7 ends that ray immediately. That step and all later steps are not emitted, and the capture bit is discarded.
- KNIGHT order is UUL, UUR, LLU, RRU, DDL, DDR, LLD, RRD.
  - Only words with bit7=1 are emitted; `mv_to`=[5:0] and `mv_cap`=[6].
  - Invalid words are skipped in zero cycles.
- After the final move is accepted: go to DONE, `done`=1 for exactly one cycle, then IDLE.
- A snapshot with no moves goes to DONE directly: load at edge N, `done` high in cycle N+1.
- Each accepted move (`mv_valid && mv_ready`) increments `move_count`. The count holds its value in IDLE until the next load.
- Skipping is priority-encoded over remaining directions, so there are never bubbles between moves.

## Timing
- Reset values:
  - state IDLE, `load_ready`=1.
  - `mv_valid`=0, `mv_from`=0, `mv_to`=0, `mv_cap`=0.
  - `done`=0, `move_count`=0.
  - All captured words cleared to 0.
- Latency: load at edge N gives the first `mv_valid` in cycle N+1.
- `mv_valid`, `mv_from`, `mv_to` and `mv_cap` are registered outputs.
- Throughput is one move per cycle while `mv_ready`=1.
- While `mv_valid && !mv_ready`, all `mv_*` outputs hold stable. `mv_valid` never drops without acceptance.
- `mv_ready` may toggle arbitrarily; the block does not depend on it combinationally for `mv_valid`.
- `done` and `load_ready` are never high in the same cycle.
- Reset asserted mid-stream:
  - Immediate return to IDLE with all outputs at reset values.
  - The partial snapshot is discarded and no `done` is emitted.

## Structure
- `chess_pkg` holds:
  - `SQ_W`.
  - The slide field positions (LEN_MSB=2, CAP_BIT=3).
  - The knight field positions (DST, CAP_BIT=6, VLD_BIT=7).
  - The direction enum and its 8-entry rank/file delta constant table.
  - The state enum.
- One sub-module, `sq_step`, is combinational: origin, rank/file delta and step k in; destination square and on-board flag out. It is instantiated once, indexed by the current direction.

## Test plan
- from_sq=27 (d4), U_in len=2 cap=1, all others 0, `mv_ready`=1:
  - Moves (27,35,0) and (27,43,1) in cycles N+1 and N+2.
  - `done` in N+3, `move_count`=2.
- All slide len=0 and all knight bit7=0: no `mv_valid`, `done` at N+1, `move_count`=0.
- from_sq=0 (a1), L_in len=3 and D_in len=2 (off-board), R_in len=1:
  - Only (0,1,0) is emitted; L/D are fully suppressed.
- from_sq=28: UUL=0xE3, meaning dst 35 with cap and valid (per field definition, {1,1,100011}), and RRD=0x96, all others invalid.
  - Emits (28,35,1) then (28,22,0); skipped slots cost no cycles.
- `mv_ready` held low 5 cycles on the first move: `mv_to` is stable across all 5 cycles, and the sequence continues unchanged afterwards.
- Assert `RESET_N` mid-SLIDE after 3 of 7 moves:
  - Outputs return to reset values and `load_ready`=1.
  - A new load after release produces the fresh sequence from its start.
